// File: rtl/simon_seq_engine.sv
// Simon sequence engine: pattern memory, timed playback, repeat checking,
// score and win reporting, all driven from debounced board inputs.
module simon_seq_engine #(
   parameter int NUM_BTN     = 4,
   parameter int DEPTH       = 64,
   parameter int HOLD_CYCLES = 4,
   parameter int ADDR_W      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               level,
   input  logic [NUM_BTN-1:0] pattern,
   input  logic               enter,
   output logic [NUM_BTN-1:0] pattern_leds,
   output logic [2:0]         mode_leds,
   output logic [ADDR_W:0]    score,
   output logic               win
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
   localparam logic [ADDR_W:0]    CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]    CNT_FULL  = (ADDR_W+1)'(DEPTH);
   localparam logic [NUM_BTN-1:0] PAT_ONE   = NUM_BTN'(1);

   typedef enum logic [1:0] {
      S_INPUT,
      S_PLAY,
      S_REPEAT,
      S_DONE
   } state_t;

   state_t state, state_n;

   logic [NUM_BTN-1:0] mem [DEPTH];

   logic [ADDR_W:0]    count, count_n;
   logic [ADDR_W:0]    play_idx, play_n;
   logic [ADDR_W:0]    rep_idx, rep_n;
   logic [ADDR_W:0]    score_n;
   logic [HOLD_W-1:0]  hold_cnt, hold_n;
   logic               win_n;
   logic [2:0]         mode_n;
   logic               mem_we;

   logic               enter_q;
   logic               enter_pulse;
   logic               level_q;
   logic               level_seen;
   logic               level_eff;
   logic               onehot;
   logic               legal;
   logic               last_hold;
   logic               play_last;
   logic               rep_last;
   logic               match;
   logic [NUM_BTN-1:0] play_pat;
   logic [NUM_BTN-1:0] rep_pat;

   assign enter_pulse = enter & ~enter_q;

   // Before the first post-reset edge the live level is what will be frozen.
   assign level_eff = level_seen ? level_q : level;
   assign onehot    = ((pattern & (pattern - PAT_ONE)) == '0);
   assign legal     = (pattern != '0) & (level_eff | onehot);

   assign play_pat  = mem[play_idx[ADDR_W-1:0]];
   assign rep_pat   = mem[rep_idx[ADDR_W-1:0]];
   assign match     = (pattern == rep_pat);

   assign last_hold = (hold_cnt == HOLD_LAST);
   assign play_last = (play_idx == count - CNT_ONE);
   assign rep_last  = (rep_idx == count - CNT_ONE);

   always_comb begin
      pattern_leds = pattern;
      if (state == S_PLAY || state == S_DONE) begin
         pattern_leds = play_pat;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      play_n  = play_idx;
      rep_n   = rep_idx;
      hold_n  = hold_cnt;
      score_n = score;
      win_n   = win;
      mem_we  = 1'b0;
      unique case (state)
         S_INPUT: begin
            if (enter_pulse && legal) begin
               mem_we  = 1'b1;
               count_n = count + CNT_ONE;
               play_n  = '0;
               hold_n  = '0;
               state_n = S_PLAY;
            end
         end
         S_PLAY, S_DONE: begin
            if (last_hold) begin
               hold_n = '0;
               if (play_last) begin
                  play_n = '0;
                  if (state == S_PLAY) begin
                     rep_n   = '0;
                     state_n = S_REPEAT;
                  end
               end else begin
                  play_n = play_idx + CNT_ONE;
               end
            end else begin
               hold_n = hold_cnt + HOLD_ONE;
            end
         end
         S_REPEAT: begin
            if (enter_pulse && legal) begin
               if (match) begin
                  if (rep_last) begin
                     score_n = count;
                     if (count == CNT_FULL) begin
                        win_n   = 1'b1;
                        play_n  = '0;
                        hold_n  = '0;
                        state_n = S_DONE;
                     end else begin
                        state_n = S_INPUT;
                     end
                  end else begin
                     rep_n = rep_idx + CNT_ONE;
                  end
               end else begin
                  win_n   = 1'b0;
                  play_n  = '0;
                  hold_n  = '0;
                  state_n = S_DONE;
               end
            end
         end
         default: state_n = S_INPUT;
      endcase
   end

   always_comb begin
      mode_n = 3'b001;
      unique case (1'b1)
         (state_n == S_PLAY):   mode_n = 3'b010;
         (state_n == S_REPEAT): mode_n = 3'b100;
         (state_n == S_DONE):   mode_n = 3'b111;
         default:               mode_n = 3'b001;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_INPUT;
         count      <= '0;
         play_idx   <= '0;
         rep_idx    <= '0;
         hold_cnt   <= '0;
         score      <= '0;
         win        <= 1'b0;
         mode_leds  <= 3'b001;
         enter_q    <= 1'b1;
         level_q    <= 1'b0;
         level_seen <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         play_idx  <= play_n;
         rep_idx   <= rep_n;
         hold_cnt  <= hold_n;
         score     <= score_n;
         win       <= win_n;
         mode_leds <= mode_n;
         enter_q   <= enter;
         if (!level_seen) begin
            level_q    <= level;
            level_seen <= 1'b1;
         end
      end
   end

   // Contents survive reset; count=0 keeps stale entries unread.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[count[ADDR_W-1:0]] <= pattern;
      end
   end

endmodule
